// File: rtl/quiz_scroller.sv
// quiz_scroller: holds N_ROWS problem rows, grades handwritten digits against the
// answer row, fetches new problems by req/valid, and animates a one-row scroll
// paced by the VGA end-of-frame.
module quiz_scroller #(
    parameter int N_ROWS    = 4,
    parameter int ROW_W     = 24,
    parameter int ANS_ROW   = 2,
    parameter int DIGIT_LSB = 0,
    parameter int ROW_H     = 150,
    parameter int STEP      = 3,
    parameter int H_END     = 640,
    parameter int V_END     = 480,
    parameter int SCORE_W   = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [10:0]               i_x,
    input  logic [10:0]               i_y,
    input  logic [3:0]                i_digit_answered,
    input  logic                      i_digit_identified,
    input  logic                      i_pause,
    input  logic [ROW_W-1:0]          i_prob,
    input  logic                      i_prob_valid,
    output logic                      o_prob_req,
    output logic [N_ROWS*ROW_W-1:0]   o_rows,
    output logic [2*N_ROWS-1:0]       o_marks,
    output logic [10:0]               o_displacement,
    output logic                      o_busy,
    output logic [SCORE_W-1:0]        o_score,
    output logic [SCORE_W-1:0]        o_streak,
    output logic                      o_overrun
);

    localparam int CNT_W = $clog2(ANS_ROW + 1);

    typedef enum logic [1:0] {FILL, IDLE, LOAD, SCROLL} state_t;

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               fill_cnt_q, fill_cnt_d;
    logic [N_ROWS-1:0][ROW_W-1:0]   rows_q, rows_d;
    logic [N_ROWS-1:0][1:0]         marks_q, marks_d;
    logic [10:0]                    disp_q, disp_d;
    logic [SCORE_W-1:0]             score_q, score_d;
    logic [SCORE_W-1:0]             streak_q, streak_d;
    logic                           pend_v_q, pend_v_d;
    logic [3:0]                     pend_q, pend_d;
    logic                           req_q, req_d;
    logic                           ovr_q, ovr_d;
    logic                           at_end_q;

    logic        at_end, tick, xfer, ans_v;
    logic [3:0]  ans, nib;
    logic [11:0] disp_sum;

    assign at_end   = (i_x == 11'(H_END)) && (i_y == 11'(V_END));
    assign tick     = at_end && !at_end_q;
    assign xfer     = req_q && i_prob_valid;
    assign nib      = rows_q[ANS_ROW][DIGIT_LSB +: 4];
    assign ans_v    = pend_v_q || i_digit_identified;
    assign ans      = pend_v_q ? pend_q : i_digit_answered;
    assign disp_sum = {1'b0, disp_q} + 12'(STEP);

    // Next-state logic for the FSM, row store, counters and pending buffer.
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        rows_d     = rows_q;
        marks_d    = marks_q;
        disp_d     = disp_q;
        score_d    = score_q;
        streak_d   = streak_q;
        pend_v_d   = pend_v_q;
        pend_d     = pend_q;
        req_d      = req_q;
        ovr_d      = 1'b0;

        case (state_q)
            FILL: begin
                if (fill_cnt_q < CNT_W'(ANS_ROW)) begin
                    if (xfer) begin
                        rows_d     = {rows_q[N_ROWS-2:0], i_prob};
                        marks_d    = {marks_q[N_ROWS-2:0], 2'b00};
                        req_d      = 1'b0;
                        fill_cnt_d = fill_cnt_q + CNT_W'(1);
                    end else begin
                        req_d = 1'b1;
                    end
                end else begin
                    rows_d  = {rows_q[N_ROWS-2:0], {ROW_W{1'b1}}};
                    marks_d = {marks_q[N_ROWS-2:0], 2'b00};
                    state_d = IDLE;
                end
            end
            IDLE: begin
                // A buffered answer wins; a strobe colliding with it is dropped.
                if (pend_v_q) begin
                    pend_v_d = 1'b0;
                    ovr_d    = i_digit_identified;
                end
                if (ans_v && nib != 4'hF) begin
                    rows_d[ANS_ROW][DIGIT_LSB +: 4] = ans;
                    if (ans == nib) begin
                        marks_d[ANS_ROW] = 2'b10;
                        if (score_q != '1)  score_d  = score_q + SCORE_W'(1);
                        if (streak_q != '1) streak_d = streak_q + SCORE_W'(1);
                    end else begin
                        marks_d[ANS_ROW] = 2'b01;
                        streak_d         = '0;
                    end
                    req_d   = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    rows_d[0] = i_prob;
                    req_d     = 1'b0;
                    state_d   = SCROLL;
                end
            end
            SCROLL: begin
                if (tick && !i_pause) begin
                    if (disp_sum >= 12'(ROW_H)) begin
                        rows_d  = {rows_q[N_ROWS-2:0], {ROW_W{1'b1}}};
                        marks_d = {marks_q[N_ROWS-2:0], 2'b00};
                        disp_d  = '0;
                        state_d = IDLE;
                    end else begin
                        disp_d = disp_sum[10:0];
                    end
                end
            end
            default: state_d = FILL;
        endcase

        if (state_q != IDLE && i_digit_identified) begin
            if (pend_v_q) begin
                ovr_d = 1'b1;
            end else begin
                pend_v_d = 1'b1;
                pend_d   = i_digit_answered;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= FILL;
            fill_cnt_q <= '0;
            rows_q     <= '1;
            marks_q    <= '0;
            disp_q     <= '0;
            score_q    <= '0;
            streak_q   <= '0;
            pend_v_q   <= 1'b0;
            pend_q     <= '0;
            req_q      <= 1'b0;
            ovr_q      <= 1'b0;
            at_end_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            rows_q     <= rows_d;
            marks_q    <= marks_d;
            disp_q     <= disp_d;
            score_q    <= score_d;
            streak_q   <= streak_d;
            pend_v_q   <= pend_v_d;
            pend_q     <= pend_d;
            req_q      <= req_d;
            ovr_q      <= ovr_d;
            at_end_q   <= at_end;
        end
    end

    assign o_prob_req     = req_q;
    assign o_rows         = rows_q;
    assign o_marks        = marks_q;
    assign o_displacement = disp_q;
    assign o_busy         = (state_q != IDLE);
    assign o_score        = score_q;
    assign o_streak       = streak_q;
    assign o_overrun      = ovr_q;

endmodule
